// File: rtl/fifo_flex_if.sv
// rtl/fifo_flex_if.sv - fifo_flex data/status bundle; peak only with FIFO_PEAK_TRACK_EN
interface fifo_flex_if #(
  parameter int B = 8,
  parameter int W = 4
);
  logic         wr;
  logic [B-1:0] wr_data;
  logic         rd;
  logic [B-1:0] rd_data;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;
  logic         clr_err;
`ifdef FIFO_PEAK_TRACK_EN
  logic [W:0]   peak;
`endif

  modport master (
    output wr, wr_data, rd, clr_err,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
`ifdef FIFO_PEAK_TRACK_EN
    , peak
`endif
  );

  modport slave (
    input  wr, wr_data, rd, clr_err,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
`ifdef FIFO_PEAK_TRACK_EN
    , peak
`endif
  );
endinterface

// File: rtl/fifo_flex.sv
// rtl/fifo_flex.sv - parametrised block-RAM FIFO, standard or FWFT read
// Optional occupancy high-water mark behind FIFO_PEAK_TRACK_EN.
module fifo_flex #(
  parameter int B     = 8,
  parameter int W     = 4,
  parameter int AF_TH = 2**W - 2,
  parameter int AE_TH = 2,
  parameter int FWFT  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  fifo_flex_if.slave  bus
);
  localparam int         DEPTH = 2**W;
  localparam logic [W:0] CAP   = DEPTH[W:0];
  localparam logic [W:0] AF_V  = AF_TH[W:0];
  localparam logic [W:0] AE_V  = AE_TH[W:0];
  localparam bit         FW    = (FWFT != 0);

  logic [B-1:0] mem [DEPTH];
  logic [B-1:0] ram_q;
  logic [B-1:0] rd_data_q;
  logic [W-1:0] wr_ptr;
  logic [W-1:0] rd_ptr;
  logic [W:0]   cnt;
  logic [W:0]   cnt_next;
  logic [W:0]   avail;
  logic         full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic         out_valid, pend, rd_pend;
  logic         empty_now, rd_acc, wr_acc, fetch, load, ram_re;

  // FWFT: pend marks ram_q holding a fetched word; out_valid marks rd_data_q as the head.
  always_comb begin
    empty_now = FW ? !out_valid : empty_q;
    rd_acc    = bus.rd & !empty_now;
    wr_acc    = bus.wr & (!full_q | rd_acc);
    cnt_next  = cnt;
    if (wr_acc && !rd_acc)
      cnt_next = cnt + 1'b1;
    else if (rd_acc && !wr_acc)
      cnt_next = cnt - 1'b1;
    avail  = cnt - {{W{1'b0}}, out_valid} - {{W{1'b0}}, pend};
    load   = FW & pend & (!out_valid | rd_acc);
    fetch  = FW & (avail != '0) & (!pend | load);
    ram_re = FW ? fetch : rd_acc;
  end

  // Read-before-write keeps the full+wr+rd case returning the old word.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= bus.wr_data;
    if (ram_re)
      ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      out_valid <= 1'b0;
      pend      <= 1'b0;
      rd_pend   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (ram_re)
        rd_ptr <= rd_ptr + 1'b1;
      cnt       <= cnt_next;
      full_q    <= (cnt_next == CAP);
      empty_q   <= (cnt_next == '0);
      af_q      <= (cnt_next >= AF_V);
      ae_q      <= (cnt_next <= AE_V);
      ovf_q     <= (bus.wr & full_q & !bus.rd) | (ovf_q & !bus.clr_err);
      udf_q     <= (bus.rd & empty_now) | (udf_q & !bus.clr_err);
      rd_pend   <= rd_acc & !FW;
      pend      <= fetch | (pend & !load);
      out_valid <= load | (out_valid & !rd_acc);
      if (load || rd_pend)
        rd_data_q <= ram_q;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_now;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

`ifdef FIFO_PEAK_TRACK_EN
  logic [W:0] peak_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      peak_q <= '0;
    else if (bus.clr_err)
      peak_q <= cnt;
    else if (cnt > peak_q)
      peak_q <= cnt;
  end

  assign bus.peak = peak_q;
`else
  // peak tracking not built
`endif
endmodule

// File: tb/tb_fifo_flex.sv
// tb/tb_fifo_flex.sv - checks fifo_flex in standard and FWFT builds against queue models
module tb_fifo_flex;
  localparam int B = 8;
  localparam int W = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_flex_if #(.B(B), .W(W)) s_if ();
  fifo_flex_if #(.B(B), .W(W)) f_if ();

  fifo_flex #(.B(B), .W(W), .FWFT(0)) u_std (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));
  fifo_flex #(.B(B), .W(W), .FWFT(1)) u_fw  (.clk(clk), .rst_n(rst_n), .bus(f_if.slave));

  int errors = 0;
  int checks = 0;
  int edge_no = 0;

  // standard-mode model: rd_data shows the popped word one edge after the pop
  logic [7:0] sq[$];
  logic [7:0] s_exp_rd, s_pend_val;
  bit s_pend, s_ovf, s_udf;
  int s_peak;

  // FWFT model: words with their write edge; head visibility from prefetch timing rules
  logic [7:0] fq[$];
  int fw[$];
  int f_prev_v, f_prev_p;
  bit f_ovf, f_udf;
  int f_peak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // edge after which the FWFT head word is presented
  function automatic int f_head_v();
    int f;
    if (fw.size() == 0) return 1 << 30;
    f = (fw[0] + 1 > f_prev_v) ? fw[0] + 1 : f_prev_v;
    return (f + 1 > f_prev_p) ? f + 1 : f_prev_p;
  endfunction

  task automatic check_all();
    bit fv;
    fv = (fq.size() > 0) && (f_head_v() <= edge_no);
    chk("std_count", 32'(s_if.count), sq.size());
    chk("std_empty", 32'(s_if.empty), 32'(sq.size() == 0));
    chk("std_full", 32'(s_if.full), 32'(sq.size() == DEPTH));
    chk("std_afull", 32'(s_if.almost_full), 32'(sq.size() >= DEPTH - 2));
    chk("std_aempty", 32'(s_if.almost_empty), 32'(sq.size() <= 2));
    chk("std_ovf", 32'(s_if.overflow), 32'(s_ovf));
    chk("std_udf", 32'(s_if.underflow), 32'(s_udf));
    chk("std_rd_data", 32'(s_if.rd_data), 32'(s_exp_rd));
    chk("fw_count", 32'(f_if.count), fq.size());
    chk("fw_empty", 32'(f_if.empty), 32'(!fv));
    if (fv) chk("fw_rd_data", 32'(f_if.rd_data), 32'(fq[0]));
    chk("fw_full", 32'(f_if.full), 32'(fq.size() == DEPTH));
    chk("fw_afull", 32'(f_if.almost_full), 32'(fq.size() >= DEPTH - 2));
    chk("fw_aempty", 32'(f_if.almost_empty), 32'(fq.size() <= 2));
    chk("fw_ovf", 32'(f_if.overflow), 32'(f_ovf));
    chk("fw_udf", 32'(f_if.underflow), 32'(f_udf));
`ifdef FIFO_PEAK_TRACK_EN
    chk("std_peak", 32'(s_if.peak), s_peak);
    chk("fw_peak", 32'(f_if.peak), f_peak);
`endif
  endtask

  task automatic drive(input bit w, input bit r, input logic [7:0] d, input bit c);
    s_if.wr = w; s_if.rd = r; s_if.wr_data = d; s_if.clr_err = c;
    f_if.wr = w; f_if.rd = r; f_if.wr_data = d; f_if.clr_err = c;
  endtask

  task automatic tick(input bit w, input bit r, input logic [7:0] d, input bit c);
    int e, hv, ssz, fsz;
    bit s_rd_ok, s_wr_ok, f_vis, f_rd_ok, f_wr_ok;
    drive(w, r, d, c);
    ssz = sq.size();
    fsz = fq.size();
    e = edge_no + 1;
    s_peak = c ? ssz : ((ssz > s_peak) ? ssz : s_peak);
    f_peak = c ? fsz : ((fsz > f_peak) ? fsz : f_peak);

    s_rd_ok = r && (ssz > 0);
    s_wr_ok = w && ((ssz < DEPTH) || s_rd_ok);
    s_ovf = (w && (ssz == DEPTH) && !r) || (s_ovf && !c);
    s_udf = (r && (ssz == 0)) || (s_udf && !c);
    if (s_pend) s_exp_rd = s_pend_val;
    s_pend = s_rd_ok;
    if (s_rd_ok) s_pend_val = sq.pop_front();
    if (s_wr_ok) sq.push_back(d);

    hv = f_head_v();
    f_vis = (fsz > 0) && (hv <= e - 1);
    f_rd_ok = r && f_vis;
    f_wr_ok = w && ((fsz < DEPTH) || f_rd_ok);
    f_ovf = (w && (fsz == DEPTH) && !r) || (f_ovf && !c);
    f_udf = (r && !f_vis) || (f_udf && !c);
    if (f_rd_ok) begin
      f_prev_v = hv;
      f_prev_p = e;
      void'(fq.pop_front());
      void'(fw.pop_front());
    end
    if (f_wr_ok) begin
      fq.push_back(d);
      fw.push_back(e);
    end

    @(posedge clk);
    edge_no = e;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sq.delete(); fq.delete(); fw.delete();
    s_pend = 0; s_exp_rd = '0; s_pend_val = '0; s_ovf = 0; s_udf = 0; s_peak = 0;
    f_prev_v = -100; f_prev_p = -100; f_ovf = 0; f_udf = 0; f_peak = 0;
    chk("rst_std_count", 32'(s_if.count), 0);
    chk("rst_std_empty", 32'(s_if.empty), 1);
    chk("rst_std_rd_data", 32'(s_if.rd_data), 0);
    chk("rst_fw_count", 32'(f_if.count), 0);
    chk("rst_fw_empty", 32'(f_if.empty), 1);
    chk("rst_fw_rd_data", 32'(f_if.rd_data), 0);
`ifdef FIFO_PEAK_TRACK_EN
    chk("rst_std_peak", 32'(s_if.peak), 0);
`endif
    check_all();
    @(negedge clk);
    drive(0, 0, '0, 0);
    rst_n = 1'b1;
  endtask

  bit rw, rr, rc;
  int ph;

  initial begin
    drive(0, 0, '0, 0);
    @(posedge clk);
    #1;
    do_reset();

    // fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      tick(1, 0, 8'(i), 0);
      chk("afull_ramp", 32'(s_if.almost_full), 32'(i >= 14));
    end
    chk("fill_full", 32'(s_if.full), 1);
    chk("fill_count", 32'(s_if.count), 16);

    // overflow on full, then clear
    tick(1, 0, 8'hAA, 0);
    chk("ovf_set", 32'(s_if.overflow), 1);
    chk("ovf_count", 32'(s_if.count), 16);
    tick(0, 0, '0, 1);
    chk("ovf_clr", 32'(s_if.overflow), 0);

    // full with simultaneous wr+rd, then drain
    tick(1, 1, 8'h77, 0);
    chk("full_wr_rd_count", 32'(s_if.count), 16);
    for (int j = 0; j < 16; j++) begin
      tick(0, 1, '0, 0);
      chk("drain_seq", 32'(s_if.rd_data), j + 1);
    end
    tick(0, 0, '0, 0);
    chk("drain_last", 32'(s_if.rd_data), 32'h77);
    chk("drain_empty", 32'(s_if.empty), 1);

    // read on empty alongside a write: no bypass
    tick(1, 1, 8'h55, 0);
    chk("udf_set", 32'(s_if.underflow), 1);
    chk("udf_count", 32'(s_if.count), 1);
    tick(0, 0, '0, 1);
    chk("udf_clr", 32'(s_if.underflow), 0);
    tick(0, 0, '0, 0);
    tick(0, 0, '0, 0);
    tick(0, 1, '0, 0);
    tick(0, 0, '0, 0);
    chk("udf_next_word", 32'(s_if.rd_data), 32'h55);
    tick(0, 0, '0, 1);

    // FWFT fall-through latency
    tick(1, 0, 8'h3C, 0);
    chk("fw_3c_e1", 32'(f_if.empty), 1);
    tick(0, 0, '0, 0);
    chk("fw_3c_e2", 32'(f_if.empty), 1);
    tick(0, 0, '0, 0);
    chk("fw_3c_empty", 32'(f_if.empty), 0);
    chk("fw_3c_data", 32'(f_if.rd_data), 32'h3C);
    tick(0, 1, '0, 0);
    chk("fw_pop_empty", 32'(f_if.empty), 1);
    chk("fw_pop_count", 32'(f_if.count), 0);

    // random traffic alternating fill-biased and drain-biased phases
    for (int i = 0; i < 400; i++) begin
      ph = (i / 40) % 2;
      rw = (ph == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      rr = (ph == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      rc = ($urandom_range(0, 15) == 0);
      tick(rw, rr, 8'($urandom), rc);
    end

    // reset mid-burst with 7 words queued
    tick(0, 0, '0, 0);
    do_reset();
    for (int i = 0; i < 7; i++) tick(1, 0, 8'($urandom), 0);
    tick(1, 1, 8'hE1, 0);
    chk("pre_rst_count", 32'(s_if.count), 7);
`ifdef FIFO_PEAK_TRACK_EN
    chk("pre_rst_peak", 32'(s_if.peak), 7);
`endif
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 0, 8'(8'hC0 + i), 0);
    for (int i = 0; i < 6; i++) tick(0, 1, '0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
